// File: rtl/mem_pkg.sv
// Shared types and limits for the memory load path.
// Imported by load_extract and mem_load_unit.
package mem_pkg;

  localparam int unsigned MEM_LATENCY_MAX = 15;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    LD_WORD = 2'b00,
    LD_HALF = 2'b01,
    LD_BYTE = 2'b10,
    LD_RSVD = 2'b11
  } load_type_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    READ = 2'b01,
    DONE = 2'b10,
    ERR  = 2'b11
  } load_state_t;

  // Byte loads never fault; halfwords need even offsets.
  function automatic logic is_misaligned(
    input load_type_t t,
    input logic [1:0] off
  );
    logic bad;
    unique case (1'b1)
      (t == LD_BYTE): bad = 1'b0;
      (t == LD_HALF): bad = off[0];
      default:        bad = |off;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_extract.sv
// Lane select plus sign/zero extension of a little-endian word.
// Purely combinational; shared with store-path reference models.
module load_extract
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  load_type_t  ltype,
  input  logic        uns,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        bfill;
  logic        hfill;

  always_comb begin
    byte_sel = word[7:0];
    unique case (offset)
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      2'd3: byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
  end

  assign half_sel = offset[1] ? word[31:16] : word[15:0];
  assign bfill = ~uns & byte_sel[7];
  assign hfill = ~uns & half_sel[15];

  always_comb begin
    result = word;
    unique case (ltype)
      LD_BYTE: result = {{24{bfill}}, byte_sel};
      LD_HALF: result = {{16{hfill}}, half_sel};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/mem_load_unit.sv
// Multicycle load unit: word read, fixed latency, extract into MDR.
// Define MISALIGN_EXC_EN to trap misaligned loads via MisalignExc.
module mem_load_unit
  import mem_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              LoadStart,
  input  logic [1:0]        LoadType,
  input  logic              LoadUnsigned,
  input  logic [DATA_W-1:0] Address,
  output logic [DATA_W-1:0] MemAddr,
  output logic              MemRead,
  input  logic [DATA_W-1:0] MemDataIn,
  output logic [DATA_W-1:0] MDR,
  output logic              LoadBusy,
  output logic              LoadDone
`ifdef MISALIGN_EXC_EN
  ,
  output logic              MisalignExc
`endif
);

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(MEM_LATENCY - 1);

  load_state_t      state;
  load_type_t       ltype_q;
  logic             uns_q;
  logic [1:0]       off_q;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      ext;

  load_extract u_extract (
    .word   (MemDataIn),
    .offset (off_q),
    .ltype  (ltype_q),
    .uns    (uns_q),
    .result (ext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ltype_q  <= LD_WORD;
      uns_q    <= 1'b0;
      off_q    <= 2'b00;
      cnt      <= '0;
      MemAddr  <= '0;
      MemRead  <= 1'b0;
      MDR      <= '0;
      LoadBusy <= 1'b0;
      LoadDone <= 1'b0;
`ifdef MISALIGN_EXC_EN
      MisalignExc <= 1'b0;
`endif
    end else begin
      LoadDone <= 1'b0;
`ifdef MISALIGN_EXC_EN
      MisalignExc <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (LoadStart) begin
            ltype_q  <= load_type_t'(LoadType);
            uns_q    <= LoadUnsigned;
            off_q    <= Address[1:0];
            cnt      <= '0;
            LoadBusy <= 1'b1;
`ifdef MISALIGN_EXC_EN
            if (is_misaligned(load_type_t'(LoadType),
                              Address[1:0])) begin
              state       <= ERR;
              MisalignExc <= 1'b1;
            end else begin
              state   <= READ;
              MemRead <= 1'b1;
              MemAddr <= {Address[DATA_W-1:2], 2'b00};
            end
`else
            state   <= READ;
            MemRead <= 1'b1;
            MemAddr <= {Address[DATA_W-1:2], 2'b00};
`endif
          end
        end
        READ: begin
          if (cnt == CNT_LAST) begin
            MDR      <= ext;
            MemRead  <= 1'b0;
            LoadDone <= 1'b1;
            state    <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          state    <= IDLE;
          LoadBusy <= 1'b0;
        end
        // ERR, and any unreachable encoding, falls back to IDLE
        default: begin
          state    <= IDLE;
          MemRead  <= 1'b0;
          LoadBusy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_load_unit.sv
// Scoreboard bench for mem_load_unit with a byte-level reference model.
// Build with MISALIGN_EXC_EN to also exercise the misalignment trap.
module tb_mem_load_unit;

  localparam int unsigned LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        LoadStart = 1'b0;
  logic [1:0]  LoadType = 2'b00;
  logic        LoadUnsigned = 1'b0;
  logic [31:0] Address = '0;
  logic [31:0] MemAddr;
  logic        MemRead;
  logic [31:0] MemDataIn = '0;
  logic [31:0] MDR;
  logic        LoadBusy;
  logic        LoadDone;
`ifdef MISALIGN_EXC_EN
  logic        MisalignExc;
`endif

  always #5 clk = ~clk;

  mem_load_unit #(.MEM_LATENCY(LAT), .DATA_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .LoadStart    (LoadStart),
    .LoadType     (LoadType),
    .LoadUnsigned (LoadUnsigned),
    .Address      (Address),
    .MemAddr      (MemAddr),
    .MemRead      (MemRead),
    .MemDataIn    (MemDataIn),
    .MDR          (MDR),
    .LoadBusy     (LoadBusy),
    .LoadDone     (LoadDone)
`ifdef MISALIGN_EXC_EN
    ,
    .MisalignExc  (MisalignExc)
`endif
  );

  typedef struct {
    logic [31:0] mdr;
    int          e0;
    logic [31:0] addr;
  } exp_t;

  exp_t sbq[$];
  int passed = 0;
  int total = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int exc_pending = 0;
  int exc_seen = 0;
  logic prev_done = 1'b0;
  logic [31:0] last_mdr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference: pick bytes of the word arithmetically, then extend.
  function automatic logic [31:0] ref_load(input logic [31:0] d,
                                           input logic [31:0] a,
                                           input logic [1:0]  t,
                                           input logic        u);
    int unsigned off;
    int unsigned w;
    longint v;
    if (t == 2'd1) begin
      w = 16;
      off = (a % 4 >= 2) ? 2 : 0;
    end else if (t == 2'd2) begin
      w = 8;
      off = a % 4;
    end else begin
      return d;
    end
    v = longint'((d >> (8 * off)) % (32'd1 << w));
    if (!u && v >= (longint'(1) << (w - 1)))
      v = v - (longint'(1) << w);
    return 32'(v);
  endfunction

  function automatic bit ref_misaligned(input logic [31:0] a,
                                        input logic [1:0]  t);
    if (t == 2'd2) return 1'b0;
    if (t == 2'd1) return (a % 2) != 0;
    return (a % 4) != 0;
  endfunction

  // Monitor: every observed completion is matched against the queue.
  always @(negedge clk) begin
    if (!rst_n) begin
      rd_cnt = 0;
      prev_done = 1'b0;
    end else begin
      if (MemRead) begin
        rd_cnt++;
        if (sbq.size() == 0)
          check("unexpected_memread", 32'(MemRead), 32'd0);
        else begin
          check("memaddr", MemAddr, sbq[0].addr & ~32'd3);
          check("busy_in_read", 32'(LoadBusy), 32'd1);
        end
      end
      if (LoadDone) begin
        if (prev_done)
          check("done_pulse_width", 32'(prev_done), 32'd0);
        if (sbq.size() == 0)
          check("spurious_done", 32'(LoadDone), 32'd0);
        else begin
          exp_t e;
          e = sbq.pop_front();
          check("mdr", MDR, e.mdr);
          check("read_cycles", 32'(rd_cnt), 32'(LAT));
          check("done_latency", 32'(cyc - e.e0), 32'(LAT));
          check("read_dropped", 32'(MemRead), 32'd0);
        end
        rd_cnt = 0;
      end
`ifdef MISALIGN_EXC_EN
      if (MisalignExc) begin
        check("exc_expected", 32'(exc_pending > 0), 32'd1);
        check("exc_no_done", 32'(LoadDone), 32'd0);
        if (exc_pending > 0) exc_pending--;
        exc_seen++;
      end
`endif
      prev_done = LoadDone;
    end
  end

  task automatic start(input logic [31:0] a, input logic [1:0] t,
                       input logic u, input logic [31:0] d,
                       input logic [31:0] e);
    @(posedge clk); #1;
    LoadStart = 1'b1;
    Address = a;
    LoadType = t;
    LoadUnsigned = u;
    MemDataIn = d;
    @(posedge clk); #1;
    LoadStart = 1'b0;
    sbq.push_back('{e, cyc, a});
    Address = $urandom;
    LoadType = 2'($urandom);
    LoadUnsigned = 1'($urandom);
  endtask

  task automatic wait_done();
    int n = 0;
    while (n < 40) begin
      @(negedge clk);
      if (LoadDone) break;
      n++;
    end
    if (n >= 40) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic load(input logic [31:0] a, input logic [1:0] t,
                      input logic u, input logic [31:0] d,
                      input logic [31:0] e, input bit extra);
    start(a, t, u, d, e);
    if (extra) begin
      @(posedge clk); #1;
      LoadStart = 1'b1;
      Address = $urandom;
      @(posedge clk); #1;
      LoadStart = 1'b0;
    end
    wait_done();
    if (extra) begin
      LoadStart = 1'b1;
      @(posedge clk); #1;
      LoadStart = 1'b0;
    end
    last_mdr = e;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("mdr_hold", MDR, e);
  endtask

  task automatic misaligned(input logic [31:0] a, input logic [1:0] t);
    int n = 0;
    int seen0 = exc_seen;
    @(posedge clk); #1;
    LoadStart = 1'b1;
    Address = a;
    LoadType = t;
    exc_pending++;
    @(posedge clk); #1;
    LoadStart = 1'b0;
    while (n < 10 && exc_seen == seen0) begin
      @(negedge clk);
      n++;
    end
    check("exc_seen", 32'(exc_seen - seen0), 32'd1);
    repeat (2) @(negedge clk);
    check("exc_mdr_kept", MDR, last_mdr);
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  t;
    logic        u;
    repeat (3) @(negedge clk);
    check("rst_mdr", MDR, 32'd0);
    check("rst_memaddr", MemAddr, 32'd0);
    check("rst_memread", 32'(MemRead), 32'd0);
    check("rst_busy", 32'(LoadBusy), 32'd0);
    check("rst_done", 32'(LoadDone), 32'd0);
`ifdef MISALIGN_EXC_EN
    check("rst_exc", 32'(MisalignExc), 32'd0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;

    load(32'h100, 2'd0, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
`ifdef MISALIGN_EXC_EN
    misaligned(32'h101, 2'd0);
`endif
    load(32'h203, 2'd2, 1'b0, 32'h80112233, 32'hFFFFFF80, 1'b0);
    load(32'h203, 2'd2, 1'b1, 32'h80112233, 32'h00000080, 1'b0);
    load(32'h102, 2'd1, 1'b0, 32'h8001ABCD, 32'hFFFF8001, 1'b0);
    load(32'h100, 2'd1, 1'b1, 32'h12349876, 32'h00009876, 1'b1);

    // Abort a load mid-read with reset.
    start(32'h300, 2'd0, 1'b0, 32'h55AA55AA, 32'h55AA55AA);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_memread", 32'(MemRead), 32'd0);
    check("abort_mdr", MDR, 32'd0);
    check("abort_busy", 32'(LoadBusy), 32'd0);
    check("abort_done", 32'(LoadDone), 32'd0);
    sbq.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    last_mdr = '0;
    repeat (LAT + 3) @(posedge clk);
    load(32'h7FC, 2'd3, 1'b1, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0);

    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      d = $urandom;
      t = 2'($urandom);
      u = 1'($urandom);
`ifdef MISALIGN_EXC_EN
      if (ref_misaligned(a, t)) begin
        misaligned(a, t);
        continue;
      end
`endif
      load(a, t, u, d, ref_load(d, a, t, u), (i % 5) == 0);
    end

    repeat (LAT + 4) @(negedge clk);
    check("queue_empty", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_load_unit.md
Name: mem_load_unit

Overview:
- Read-side counterpart of the memory write-data path in the multicycle CPU.
- On a start pulse from the control FSM, it issues a word read to data memory and waits a fixed memory latency.
- It then extracts the byte, halfword or word, applies sign or zero extension, and registers the result into the MDR.
- It signals completion back to the control FSM.

Parameters:
- MEM_LATENCY, 1: cycles MemRead stays asserted before MemDataIn is valid. Legal range 1..15.
- DATA_W, 32: data and address width. Only 32 is supported.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- LoadStart  input  1  single-cycle request from the control FSM, sampled only in IDLE.
- LoadType  input  2  00 = word, 01 = halfword, 10 = byte, 11 = reserved and treated as word.
- LoadUnsigned  input  1  1 = zero-extend, 0 = sign-extend. Ignored for word loads.
- Address  input  32  byte address, sampled with LoadStart.
- MemAddr  output  32  word-aligned address to memory: latched Address[31:2] followed by 2'b00.
- MemRead  output  1  memory read strobe.
- MemDataIn  input  32  memory read word, little-endian (byte 0 = bits [7:0]).
- MDR  output  32  extended load result.
- LoadBusy  output  1  high in any state other than IDLE.
- LoadDone  output  1  one-cycle completion pulse.
- MisalignExc  output  1  one-cycle misalignment pulse. Present only with the optional feature.

Behaviour:
- Reset values: state IDLE; MDR 0; MemAddr 0; MemRead 0; LoadBusy 0; LoadDone 0; MisalignExc 0; latency counter 0.
- Reset mid-operation aborts immediately and drops MemRead with no completion pulse.
- States: IDLE, READ, DONE, and ERR (ERR only with the optional feature).
- IDLE:
  - On LoadStart=1 at edge E0: latch Address, LoadType and LoadUnsigned; clear the counter; go to READ.
  - Otherwise stay in IDLE.
- READ:
  - MemRead=1 and MemAddr held stable.
  - Counter increments each cycle.
  - At the edge where the counter reaches MEM_LATENCY-1 (edge E0+MEM_LATENCY): capture the extracted MemDataIn into MDR and go to DONE.
- DONE:
  - MemRead=0 and LoadDone=1 for exactly one cycle; then return to IDLE.
  - MDR is valid from the start of DONE.
  - Total latency: LoadDone is visible in the cycle after edge E0+MEM_LATENCY.
- LoadStart while LoadBusy=1 is ignored and not queued.
- A LoadStart in the same cycle as LoadDone is ignored, because the state is not IDLE.
- Address, LoadType and LoadUnsigned changing during READ have no effect; only the latched copies are used.
- MDR holds its value between loads. It changes only at a DONE capture or at reset.
- Extraction, where a = latched Address[1:0]:
  - Byte: MemDataIn[8a+7:8a].
  - Halfword: MemDataIn[15:0] if a[1]=0, else MemDataIn[31:16]. a[0] is ignored.
  - Word: the full word.
- Extension fills bits [31:8] (byte) or [31:16] (halfword) with the loaded MSB when LoadUnsigned=0, and with zeros when LoadUnsigned=1.

Optional Feature:
- Macro: MISALIGN_EXC_EN.
- With the macro defined:
  - A misaligned request goes from IDLE to ERR with no memory access; MemRead stays 0.
  - Misaligned means a word load with a≠0, or a halfword load with a[0]=1.
  - ERR lasts one cycle with MisalignExc=1, LoadDone=0 and MDR unchanged; then IDLE.
- Without the macro:
  - The MisalignExc port is absent and there is no ERR state.
  - Misaligned requests proceed using the extraction rules above, with low address bits ignored as specified.

Decomposition:
- Package mem_pkg holds:
  - load_type_t enum (LD_WORD, LD_HALF, LD_BYTE, LD_RSVD).
  - load_state_t enum (IDLE, READ, DONE, ERR).
  - The MEM_LATENCY maximum constant.
- Sub-module load_extract: purely combinational lane selection plus sign/zero extension.
  - Inputs: word, offset, type, unsigned flag. Output: 32-bit result.
  - Reused later by the store path for verification models.

Test Plan:
- MEM_LATENCY=1, Address=0x100, word load, MemDataIn=0xDEADBEEF → MemRead high 1 cycle, MemAddr=0x100, LoadDone in cycle E0+2, MDR=0xDEADBEEF.
- MEM_LATENCY=3, Address=0x203, signed byte, MemDataIn=0x80112233 → MemAddr=0x200, MemRead high 3 cycles, MDR=0xFFFFFF80. Repeat unsigned → MDR=0x00000080.
- Address=0x102, signed halfword, MemDataIn=0x8001ABCD → MDR=0xFFFF8001. Unsigned with MemDataIn=0x12349876 at offset 0 → MDR=0x00009876.
- Second LoadStart pulse during READ and in the LoadDone cycle → ignored; exactly one LoadDone; MDR reflects only the first load.
- rst_n low mid-READ, then released → MemRead=0 immediately, MDR=0, no LoadDone. A following load completes normally.
- With MISALIGN_EXC_EN: word load at 0x101 → MemRead never asserts, MisalignExc pulses 1 cycle, LoadDone=0, MDR keeps its previous value 0xDEADBEEF.
